mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters.
  - Port 0: the cpu core (mem_cmd/mem_addr/write_data).
  - Port 1: an external requester (program loader / debug DMA).
- Grants at most one access per cycle, with round-robin fairness on contention.
- Stalls the loser until it is granted.
- Returns read data with a per-port ack one cycle after the grant, matching the RAM's 1-cycle synchronous read.

Parameters:
- AW, 9, address width in words.
- DW, 16, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_cmd  in  2  port 0 command (MNONE/MREAD/MWRITE).
- cpu_addr  in  AW  port 0 word address.
- cpu_wdata  in  DW  port 0 write data.
- cpu_rdata  out  DW  port 0 read data, valid with cpu_ack.
- cpu_stall  out  1  port 0 request not granted this cycle.
- cpu_ack  out  1  port 0 access completed (pulse).
- ext_cmd  in  2  port 1 command.
- ext_addr  in  AW  port 1 address.
- ext_wdata  in  DW  port 1 write data.
- ext_rdata  out  DW  port 1 read data, valid with ext_ack.
- ext_stall  out  1  port 1 not granted.
- ext_ack  out  1  port 1 access completed.
- mem_cmd  out  2  command to RAM.
- mem_addr  out  AW  address to RAM.
- mem_wdata  out  DW  write data to RAM.
- mem_rdata  in  DW  RAM read data, valid 1 cycle after an MREAD.

Behaviour:
- Encoding: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10. 2'b11 is treated as MNONE: no request, never granted, never acked.
- Request: port n requests in a cycle when its cmd is MREAD or MWRITE.
- Grant (combinational in cycle t):
  - Only one port requesting: that port is granted.
  - Both requesting: the port not in last_grant is granted (round-robin).
  - Neither requesting: no grant; mem_cmd=MNONE, mem_addr=0, mem_wdata=0.
- The granted port's cmd/addr/wdata drive mem_* combinationally in cycle t.
- Stall: xxx_stall = request & ~grant, combinational. A stalled requester must hold cmd/addr/wdata stable until it is no longer stalled. The arbiter does not latch the request.
- Registered state:
  - last_grant (1 bit): updates only on a grant.
  - resp_valid, resp_port, resp_read: capture the grant of cycle t.
- Ack timing:
  - Cycle t+1: the ack of the granted port is 1 for exactly one cycle.
  - Read: xxx_rdata = mem_rdata, passed through in cycle t+1.
  - Write: rdata is not meaningful.
  - The other port's ack is 0 and its rdata holds its previous value (registered hold mux).
- Pipelining: a new grant may be issued in t+1 while the ack of t is presented. Sustained throughput is 1 access/cycle.
  - Under continuous contention, grants alternate 0,1,0,1…
  - A single continuous requester is granted every cycle.
- Reset values (async, immediate):
  - last_grant=1, so port 0 wins the first tie.
  - resp_valid=0, cpu_ack=ext_ack=0.
  - cpu_rdata=ext_rdata=0.
  - mem_* follow the combinational grant and are MNONE when inputs are idle.
- Reset mid-access: a grant outstanding at reset produces no ack after reset deasserts. Any RAM write already issued on the preceding edge stands.
- Reset held: stall outputs still reflect the combinational grant, but last_grant is pinned at 1.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs cpu_grant_cnt, ext_grant_cnt, cpu_stall_cnt, ext_stall_cnt, each 16 bits, plus input perf_clr.
  - Each counter increments on its event per cycle and saturates at 16'hFFFF, with no wrap.
  - perf_clr zeroes all four counters synchronously; perf_clr takes precedence over an increment in the same cycle.
  - Reset zeroes all four counters.
- Undefined: none of these ports or counters exist, and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - Command constants MNONE, MREAD, MWRITE.
  - Port index constants P_CPU=0, P_EXT=1.
  - Counter width PERF_W=16.
- Sub-module rr_arb2 holds the 2-way round-robin grant logic plus the last_grant register. Inputs: req[1:0], clk, reset. Output: gnt[1:0].
- The mem_arbiter top does the mux, response pipeline and acks.

Test Plan:
- Reset:
  - Assert reset mid-cycle with cpu_cmd=MREAD -> cpu_ack=ext_ack=0 and rdata=0 immediately.
  - After release, the first tie grants the cpu.
- Single CPU read:
  - cpu_cmd=MREAD, addr=9'h005, RAM[5]=16'hBEEF -> mem_addr=5 in cycle t.
  - cpu_ack=1 and cpu_rdata=16'hBEEF in t+1.
  - cpu_stall=0 throughout.
- Contention:
  - Both ports issue MWRITE continuously for 4 cycles (cpu data 16'h1111, ext data 16'h2222) -> grants go cpu, ext, cpu, ext.
  - The loser's stall=1 each cycle.
  - RAM writes land in that order.
- Back-to-back ext reads:
  - ext_cmd=MREAD at addrs 0,1,2 on consecutive cycles, cpu idle -> ext_ack=1 for three consecutive cycles starting t+1, with rdata matching RAM[0..2].
  - No stall.
- Reset mid-access:
  - Grant ext MREAD at t, assert reset before t+1 -> no ext_ack at t+1.
  - last_grant=1 after reset.
- Illegal command plus perf counters (MEM_ARB_PERF_EN):
  - cpu_cmd=2'b11 -> never granted or acked, and mem_cmd=MNONE.
  - 3 stalled ext cycles -> ext_stall_cnt=3.
  - perf_clr with a simultaneous event -> counter = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the RAM arbiter.
//   Command encoding (2'b11 is treated as no request), requester port indices
//   and the width of the optional performance counters.
package mem_arb_pkg;
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam int P_CPU = 0;
  localparam int P_EXT = 1;

  localparam int PERF_W = 16;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with last-grant memory.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset (last_grant forced to 1)
//   req   : request per port, bit 0 = cpu, bit 1 = ext
//   gnt   : one-hot combinational grant (all zero when nobody requests)
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  // Index of the most recently granted port; the other one wins a tie.
  logic last_grant;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port synchronous RAM between the cpu (port 0)
// and an external requester (port 1).
//   cpu_* / ext_* : per-port cmd/addr/wdata in; rdata, stall, ack out
//   mem_*         : RAM command/address/write data out, mem_rdata in
//                   (mem_rdata valid one cycle after an MREAD)
//   Grant and stall are combinational; the ack and read data of a grant
//   appear in the following cycle, so one access per cycle is sustained.
// Optional feature macro: MEM_ARB_PERF_EN adds perf_clr and four saturating
// 16-bit counters (cpu/ext grant, cpu/ext stall).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_cmd,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          cpu_ack,
  input  logic [1:0]    ext_cmd,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_stall,
  output logic          ext_ack,
`ifdef MEM_ARB_PERF_EN
  input  logic              perf_clr,
  output logic [PERF_W-1:0] cpu_grant_cnt,
  output logic [PERF_W-1:0] ext_grant_cnt,
  output logic [PERF_W-1:0] cpu_stall_cnt,
  output logic [PERF_W-1:0] ext_stall_cnt,
`endif
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          resp_valid;
  logic          resp_port;
  logic          resp_read;
  logic [DW-1:0] cpu_hold;
  logic [DW-1:0] ext_hold;

  assign req[P_CPU] = (cpu_cmd == MREAD) || (cpu_cmd == MWRITE);
  assign req[P_EXT] = (ext_cmd == MREAD) || (ext_cmd == MWRITE);

  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  always_comb begin
    mem_cmd   = MNONE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[P_CPU]) begin
      mem_cmd   = cpu_cmd;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (gnt[P_EXT]) begin
      mem_cmd   = ext_cmd;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  assign cpu_stall = req[P_CPU] & ~gnt[P_CPU];
  assign ext_stall = req[P_EXT] & ~gnt[P_EXT];

  // Response pipeline: remembers who was granted so the ack lines up with
  // the RAM's registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_port  <= 1'b0;
      resp_read  <= 1'b0;
    end else begin
      resp_valid <= |gnt;
      resp_port  <= gnt[P_EXT];
      resp_read  <= (mem_cmd == MREAD);
    end
  end

  assign cpu_ack = resp_valid & ~resp_port;
  assign ext_ack = resp_valid &  resp_port;

  // Read data passes straight through on the ack cycle and is captured so
  // the port keeps seeing it until its next read completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_hold <= '0;
      ext_hold <= '0;
    end else begin
      if (cpu_ack && resp_read) cpu_hold <= mem_rdata;
      if (ext_ack && resp_read) ext_hold <= mem_rdata;
    end
  end

  assign cpu_rdata = (cpu_ack && resp_read) ? mem_rdata : cpu_hold;
  assign ext_rdata = (ext_ack && resp_read) ? mem_rdata : ext_hold;

`ifdef MEM_ARB_PERF_EN
  logic [3:0]        perf_ev;
  logic [PERF_W-1:0] perf_cnt [4];

  assign perf_ev = {ext_stall, cpu_stall, gnt[P_EXT], gnt[P_CPU]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_perf
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        perf_cnt[gi] <= '0;
      end else if (perf_clr) begin
        perf_cnt[gi] <= '0;
      end else if (perf_ev[gi] && (perf_cnt[gi] != {PERF_W{1'b1}})) begin
        perf_cnt[gi] <= perf_cnt[gi] + 1'b1;
      end
    end
  end

  assign cpu_grant_cnt = perf_cnt[0];
  assign ext_grant_cnt = perf_cnt[1];
  assign cpu_stall_cnt = perf_cnt[2];
  assign ext_stall_cnt = perf_cnt[3];
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random plus directed stimulus for mem_arbiter, checked every
// cycle against a transaction-level model (expected grant from the
// round-robin rule, a shadow copy of RAM, and the pending ack of the previous
// cycle). The bench also provides the synchronous RAM itself.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    cpu_cmd = MNONE, ext_cmd = MNONE;
  logic [AW-1:0] cpu_addr = '0, ext_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, ext_wdata = '0;
  logic [DW-1:0] cpu_rdata, ext_rdata;
  logic          cpu_stall, ext_stall, cpu_ack, ext_ack;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
  logic          perf_clr = 1'b0;
  logic [15:0]   cpu_grant_cnt, ext_grant_cnt, cpu_stall_cnt, ext_stall_cnt;
`endif

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_ack(cpu_ack),
    .ext_cmd(ext_cmd), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_stall(ext_stall), .ext_ack(ext_ack),
`ifdef MEM_ARB_PERF_EN
    .perf_clr(perf_clr), .cpu_grant_cnt(cpu_grant_cnt), .ext_grant_cnt(ext_grant_cnt),
    .cpu_stall_cnt(cpu_stall_cnt), .ext_stall_cnt(ext_stall_cnt),
`endif
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // The RAM: one-cycle synchronous read, write on the edge.
  logic [DW-1:0] ram [512];
  always @(posedge clk) begin
    if (mem_cmd == MWRITE) ram[mem_addr] <= mem_wdata;
    if (mem_cmd == MREAD)  mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] shadow [512];
  bit            m_last = 1'b1;     // port that was granted most recently
  bit            pend_valid = 1'b0;
  bit            pend_port, pend_read;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] cpu_seen = '0, ext_seen = '0;
  bit            ms_cpu = 1'b0, ms_ext = 1'b0;
  int            pc_cg = 0, pc_eg = 0, pc_cs = 0, pc_es = 0;

  always @(negedge clk) begin
    bit rq0, rq1, rd;
    int g;
    logic [1:0]    ec;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    if (reset) begin
      pend_valid = 1'b0; m_last = 1'b1; cpu_seen = '0; ext_seen = '0;
      pc_cg = 0; pc_eg = 0; pc_cs = 0; pc_es = 0;
    end
    // response of the previous cycle's grant
    chk("cpu_ack", 32'(cpu_ack), 32'(pend_valid && !pend_port));
    chk("ext_ack", 32'(ext_ack), 32'(pend_valid && pend_port));
    if (pend_valid) begin
      if (pend_read && !pend_port) cpu_seen = pend_data;
      if (pend_read &&  pend_port) ext_seen = pend_data;
      $display("ack port=%0d %s addr=%0h data=%0h", pend_port, pend_read ? "RD" : "WR",
               pend_addr, pend_read ? pend_data : 16'h0);
    end
    if (!(pend_valid && !pend_read && !pend_port)) chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_seen));
    if (!(pend_valid && !pend_read &&  pend_port)) chk("ext_rdata", 32'(ext_rdata), 32'(ext_seen));
    // this cycle's grant
    rq0 = (cpu_cmd == MREAD) || (cpu_cmd == MWRITE);
    rq1 = (ext_cmd == MREAD) || (ext_cmd == MWRITE);
    g = -1;
    if (rq0 && rq1) g = m_last ? 0 : 1;
    else if (rq0)   g = 0;
    else if (rq1)   g = 1;
    ec = MNONE; ea = '0; ew = '0;
    if (g == 0) begin ec = cpu_cmd; ea = cpu_addr; ew = cpu_wdata; end
    if (g == 1) begin ec = ext_cmd; ea = ext_addr; ew = ext_wdata; end
    chk("mem_cmd", 32'(mem_cmd), 32'(ec));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_wdata", 32'(mem_wdata), 32'(ew));
    ms_cpu = rq0 && (g != 0);
    ms_ext = rq1 && (g != 1);
    chk("cpu_stall", 32'(cpu_stall), 32'(ms_cpu));
    chk("ext_stall", 32'(ext_stall), 32'(ms_ext));
`ifdef MEM_ARB_PERF_EN
    chk("cpu_grant_cnt", 32'(cpu_grant_cnt), pc_cg);
    chk("ext_grant_cnt", 32'(ext_grant_cnt), pc_eg);
    chk("cpu_stall_cnt", 32'(cpu_stall_cnt), pc_cs);
    chk("ext_stall_cnt", 32'(ext_stall_cnt), pc_es);
    if (reset || perf_clr) begin
      pc_cg = 0; pc_eg = 0; pc_cs = 0; pc_es = 0;
    end else begin
      if (g == 0 && pc_cg < 65535) pc_cg++;
      if (g == 1 && pc_eg < 65535) pc_eg++;
      if (ms_cpu && pc_cs < 65535) pc_cs++;
      if (ms_ext && pc_es < 65535) pc_es++;
    end
`endif
    // advance the model across the coming edge
    rd = (ec == MREAD);
    pend_valid = 1'b0;
    if (g >= 0) begin
      pend_data = shadow[ea];
      if (ec == MWRITE) shadow[ea] = ew;  // the RAM writes even under reset
      if (!reset) begin
        pend_valid = 1'b1; pend_port = (g == 1); pend_read = rd; pend_addr = ea;
        m_last = (g == 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_cmd = MNONE; ext_cmd = MNONE;
  endtask

  logic [DW-1:0] seq [4];

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 512; i++) begin
      v = DW'($urandom);
      ram[i] = v; shadow[i] = v;
    end
    ram[5] = 16'hBEEF; shadow[5] = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      ram[i] = 16'hA000 + 16'(i); shadow[i] = 16'hA000 + 16'(i);
    end

    // reset state
    #2;
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_mem_cmd", 32'(mem_cmd), 32'(MNONE));
    next_cycle(); next_cycle();
    reset = 1'b0;

    // single cpu read
    cpu_cmd = MREAD; cpu_addr = 9'h005;
    @(negedge clk);
    chk("rd_mem_addr", 32'(mem_addr), 32'h5);
    chk("rd_stall", 32'(cpu_stall), 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("rd_ack", 32'(cpu_ack), 1);
    chk("rd_data", 32'(cpu_rdata), 32'hBEEF);

    // reset asserted mid-cycle while a cpu read is being acked
    next_cycle();
    cpu_cmd = MREAD; cpu_addr = 9'h007;
    next_cycle();
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_cpu_ack", 32'(cpu_ack), 0);
    chk("mid_rst_ext_ack", 32'(ext_ack), 0);
    chk("mid_rst_cpu_rdata", 32'(cpu_rdata), 0);
    idle();
    next_cycle();
    reset = 1'b0;

    // contention: both write continuously for 4 cycles
    cpu_cmd = MWRITE; cpu_addr = 9'h010; cpu_wdata = 16'h1111;
    ext_cmd = MWRITE; ext_addr = 9'h010; ext_wdata = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq[i] = mem_wdata;
      chk("cont_loser_stall", 32'(cpu_stall | ext_stall), 1);
      next_cycle();
    end
    idle();
    chk("cont_g0", 32'(seq[0]), 32'h1111);
    chk("cont_g1", 32'(seq[1]), 32'h2222);
    chk("cont_g2", 32'(seq[2]), 32'h1111);
    chk("cont_g3", 32'(seq[3]), 32'h2222);
    chk("cont_ram", 32'(ram[9'h010]), 32'h2222);

    // back-to-back ext reads at 0,1,2
    for (int i = 0; i < 3; i++) begin
      ext_cmd = MREAD; ext_addr = AW'(i);
      @(negedge clk);
      chk("b2b_stall", 32'(ext_stall), 0);
      if (i > 0) chk("b2b_data", 32'(ext_rdata), 32'hA000 + 32'(i - 1));
      next_cycle();
    end
    idle();
    @(negedge clk);
    chk("b2b_ack_last", 32'(ext_ack), 1);
    chk("b2b_data_last", 32'(ext_rdata), 32'hA002);
    next_cycle();

    // reset before the ack of an ext read
    ext_cmd = MREAD; ext_addr = 9'h001;
    #2 reset = 1'b1;
    next_cycle();
    idle();
    chk("rst_kill_ack", 32'(ext_ack), 0);
    reset = 1'b0;
    cpu_cmd = MREAD; cpu_addr = 9'h003;
    ext_cmd = MREAD; ext_addr = 9'h004;
    @(negedge clk);
    chk("post_rst_tie_cpu", 32'(mem_addr), 32'h3);
    chk("post_rst_ext_stall", 32'(ext_stall), 1);
    next_cycle();
    cpu_cmd = MNONE;
    next_cycle();
    idle();

    // illegal command
    cpu_cmd = 2'b11;
    @(negedge clk);
    chk("ill_mem_cmd", 32'(mem_cmd), 32'(MNONE));
    chk("ill_stall", 32'(cpu_stall), 0);
    next_cycle();
    @(negedge clk);
    chk("ill_ack", 32'(cpu_ack), 0);
    next_cycle();
    idle();

    // randomized traffic; a stalled port holds its request
    for (int i = 0; i < 600; i++) begin
      int r;
      if (!ms_cpu) begin
        r = $urandom_range(0, 9);
        cpu_cmd = (r < 4) ? MREAD : (r < 7) ? MWRITE : (r < 8) ? 2'b11 : MNONE;
        cpu_addr = AW'($urandom_range(0, 15));
        cpu_wdata = DW'($urandom);
      end
      if (!ms_ext) begin
        r = $urandom_range(0, 9);
        ext_cmd = (r < 4) ? MREAD : (r < 7) ? MWRITE : (r < 8) ? 2'b11 : MNONE;
        ext_addr = AW'($urandom_range(0, 15));
        ext_wdata = DW'($urandom);
      end
      next_cycle();
    end
    idle();
    next_cycle();

`ifdef MEM_ARB_PERF_EN
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    cpu_cmd = MWRITE; cpu_addr = 9'h020; cpu_wdata = 16'h3333;
    ext_cmd = MWRITE; ext_addr = 9'h021; ext_wdata = 16'h4444;
    repeat (6) next_cycle();
    idle();
    @(negedge clk);
    chk("perf_ext_stall3", 32'(ext_stall_cnt), 3);
    chk("perf_ext_grant3", 32'(ext_grant_cnt), 3);
    next_cycle();
    perf_clr = 1'b1; cpu_cmd = MREAD; cpu_addr = 9'h002;
    next_cycle();
    perf_clr = 1'b0; idle();
    @(negedge clk);
    chk("perf_clr_wins", 32'(cpu_grant_cnt), 0);
    next_cycle();
`endif

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
